fight_round_ctrl: RTL and testbench
===================================

Name: fight_round_ctrl

Overview:
- Round sequencer and attack arbiter for the two-player keyboard fighting game.
- Consumes 4-bit action codes from the per-player keyboard decoders, already synchronised to clk.
- Drives round_start back to the decoders and runs countdown, fight and round-over phases.
- Arbitrates simultaneous attacks, enforces per-player cooldowns and maintains both health counters.

Parameters:
- HEALTH_MAX, 15: health loaded at round start; 4-bit field.
- LIGHT_DMG, 1: damage for light punch.
- HEAVY_DMG, 3: damage for heavy punch.
- LIGHT_CD, 4: cooldown cycles after a granted light punch.
- HEAVY_CD, 12: cooldown cycles after a granted heavy punch.
- COUNTDOWN_CYC, 16: clk cycles spent in COUNTDOWN; must be at least 1.
- CD_W, 8: cooldown and countdown counter width.

Ports:
- clk input 1: system clock.
- rst input 1: synchronous, active-high reset.
- p1_cmd input 4: player 1 action code. 0001 = light, 0010 = heavy, 0011 = start, others ignored.
- p1_cmd_valid input 1: one-cycle strobe qualifying p1_cmd.
- p2_cmd input 4: player 2 action code, same encoding.
- p2_cmd_valid input 1: one-cycle strobe qualifying p2_cmd.
- round_start output 1: high only in FIGHT; enables the decoders.
- state output 2: 00 IDLE, 01 COUNTDOWN, 10 FIGHT, 11 OVER.
- p1_health output 4: player 1 health.
- p2_health output 4: player 2 health.
- hit_pulse output 1: one-cycle pulse when an attack lands.
- hit_player output 1: the player who was hit (0 = P1, 1 = P2); valid with hit_pulse.
- winner output 2: 00 none, 01 P1, 10 P2.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE, round_start = 0, hit_pulse = 0, hit_player = 0, winner = 00.
  - Both health = HEALTH_MAX, both cooldowns = 0, countdown = 0, arbitration pointer = P1.
  - Reset mid-round aborts immediately; no hit_pulse is emitted.
- All outputs are registered. A command strobed in cycle N takes effect in N+1.
- IDLE:
  - A start code from either player → COUNTDOWN.
  - On entry: counter loaded with COUNTDOWN_CYC-1, both health set to HEALTH_MAX, winner cleared.
  - Attack codes are ignored.
- COUNTDOWN:
  - Counter decrements each cycle.
  - When the counter is 0 → FIGHT; round_start rises that same edge.
  - All commands are ignored.
  - Total time from the start strobe to round_start high is COUNTDOWN_CYC+1 edges.
- FIGHT:
  - A player's request is eligible when valid = 1, code ∈ {0001, 0010}, and that player's cooldown = 0.
  - One eligible request: it is granted.
  - Two eligible requests in the same cycle: the pointer's player is granted. The other request is dropped, not queued, and the pointer moves to the loser.
  - A single uncontested grant leaves the pointer unchanged.
  - Grant effects (same edge):
    - Opponent health -= DMG, saturating at 0.
    - Attacker cooldown loaded with LIGHT_CD or HEAVY_CD.
    - hit_pulse = 1 and hit_player = opponent.
  - Cooldowns decrement by 1 per cycle while nonzero; loading takes priority over decrementing.
  - If the opponent's health reaches 0 on that edge: state → OVER, round_start → 0, winner = attacker.
  - Double KO is impossible because only one grant occurs per cycle.
  - Start codes are ignored.
- OVER:
  - Health and winner hold.
  - A start code from either player → COUNTDOWN with the same entry actions as from IDLE; cooldowns are cleared.
- Ineligible requests are silently dropped; there is no error output.
- Health arithmetic is done at 5 bits and clamped at 0. No underflow wrap is permitted.

Decomposition:
- Shared package fight_pkg holds:
  - Action code constants: ACT_LIGHT = 4'h1, ACT_HEAVY = 4'h2, ACT_START = 4'h3.
  - State encoding constants: ST_IDLE, ST_COUNTDOWN, ST_FIGHT, ST_OVER.
  - Winner encodings.
  - Default damage and cooldown constants.
- One sub-module, attack_cooldown, instantiated once per player:
  - Inputs: load, load_value, clear, enable.
  - Output: ready (count == 0).

Test Plan:
- Reset then P1 start at cycle 0 (COUNTDOWN_CYC = 16) → state 01 through cycle 16; state 10 and round_start = 1 at cycle 17; both health = 15.
- In FIGHT, P1 heavy → next cycle p2_health = 12, hit_pulse = 1, hit_player = 1. A second P1 heavy 5 cycles later is dropped (health stays 12); one 13 cycles after the first is granted (health 9).
- P1 and P2 light in the same cycle with pointer = P1 → only p2_health decrements to 14. Repeat after cooldown → only p1_health decrements to 14 (pointer moved to P2).
- P2 health = 2 and P1 heavy → p2_health = 0 (saturated, not 15), state = 11, winner = 01, round_start = 0. Further attacks do not change health.
- In OVER, P2 start → COUNTDOWN, both health = 15, winner = 00. Invalid code 0111 and start codes during FIGHT cause no change.
- rst asserted in FIGHT with a simultaneous valid attack → next cycle state = 00, health = 15, hit_pulse = 0.

Source files
------------

// File: rtl/fight_pkg.sv
// Shared constants and helpers for the fight round controller.
// Action codes, state and winner encodings, default tuning values.
package fight_pkg;

  localparam logic [3:0] ACT_LIGHT = 4'h1;
  localparam logic [3:0] ACT_HEAVY = 4'h2;
  localparam logic [3:0] ACT_START = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_COUNTDOWN = 2'b01,
    ST_FIGHT     = 2'b10,
    ST_OVER      = 2'b11
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int DEF_HEALTH_MAX    = 15;
  localparam int DEF_LIGHT_DMG     = 1;
  localparam int DEF_HEAVY_DMG     = 3;
  localparam int DEF_LIGHT_CD      = 4;
  localparam int DEF_HEAVY_CD      = 12;
  localparam int DEF_COUNTDOWN_CYC = 16;
  localparam int DEF_CD_W          = 8;

  // 5-bit subtract so an oversized hit clamps at zero instead of wrapping
  function automatic logic [3:0] sat_sub(
    input logic [3:0] h,
    input logic [4:0] d
  );
    logic [4:0] r;
    r = {1'b0, h} - d;
    return (d > {1'b0, h}) ? 4'd0 : r[3:0];
  endfunction

endpackage

// File: rtl/attack_cooldown.sv
// Per-player attack cooldown counter.
// ready is high while the counter sits at zero.
module attack_cooldown
  import fight_pkg::*;
#(
  parameter int CD_W = DEF_CD_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CD_W-1:0] load_value,
  input  logic            clear,
  input  logic            enable,
  output logic            ready
);

  logic [CD_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != '0) begin
      count <= count - CD_W'(1);
    end
  end

  assign ready = (count == '0);

endmodule

// File: rtl/fight_round_ctrl.sv
// Round sequencer and attack arbiter for the two-player fighting game.
// Runs countdown/fight/over phases and keeps both health counters.
module fight_round_ctrl
  import fight_pkg::*;
#(
  parameter int HEALTH_MAX    = DEF_HEALTH_MAX,
  parameter int LIGHT_DMG     = DEF_LIGHT_DMG,
  parameter int HEAVY_DMG     = DEF_HEAVY_DMG,
  parameter int LIGHT_CD      = DEF_LIGHT_CD,
  parameter int HEAVY_CD      = DEF_HEAVY_CD,
  parameter int COUNTDOWN_CYC = DEF_COUNTDOWN_CYC,
  parameter int CD_W          = DEF_CD_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] p1_cmd,
  input  logic       p1_cmd_valid,
  input  logic [3:0] p2_cmd,
  input  logic       p2_cmd_valid,
  output logic       round_start,
  output logic [1:0] state,
  output logic [3:0] p1_health,
  output logic [3:0] p2_health,
  output logic       hit_pulse,
  output logic       hit_player,
  output logic [1:0] winner
);

  state_t          st_q;
  logic [CD_W-1:0] cnt_q;
  logic            ptr_q;
  logic            p1_rdy;
  logic            p2_rdy;
  logic            fight;
  logic            p1_atk;
  logic            p2_atk;
  logic            g1;
  logic            g2;
  logic            go;
  logic [4:0]      dmg1;
  logic [4:0]      dmg2;
  logic [3:0]      p1_rem;
  logic [3:0]      p2_rem;
  logic [CD_W-1:0] cd1_val;
  logic [CD_W-1:0] cd2_val;

  assign fight = (st_q == ST_FIGHT);

  assign p1_atk = fight && p1_cmd_valid && p1_rdy &&
                  (p1_cmd == ACT_LIGHT || p1_cmd == ACT_HEAVY);
  assign p2_atk = fight && p2_cmd_valid && p2_rdy &&
                  (p2_cmd == ACT_LIGHT || p2_cmd == ACT_HEAVY);

  // ptr_q = 0 favours P1 on a tie, 1 favours P2
  assign g1 = p1_atk && (!p2_atk || !ptr_q);
  assign g2 = p2_atk && (!p1_atk || ptr_q);

  assign go = (st_q == ST_IDLE || st_q == ST_OVER) &&
              ((p1_cmd_valid && p1_cmd == ACT_START) ||
               (p2_cmd_valid && p2_cmd == ACT_START));

  assign dmg1 = (p1_cmd == ACT_HEAVY) ? 5'(HEAVY_DMG) : 5'(LIGHT_DMG);
  assign dmg2 = (p2_cmd == ACT_HEAVY) ? 5'(HEAVY_DMG) : 5'(LIGHT_DMG);

  assign cd1_val = (p1_cmd == ACT_HEAVY) ? CD_W'(HEAVY_CD) : CD_W'(LIGHT_CD);
  assign cd2_val = (p2_cmd == ACT_HEAVY) ? CD_W'(HEAVY_CD) : CD_W'(LIGHT_CD);

  assign p2_rem = sat_sub(p2_health, dmg1);
  assign p1_rem = sat_sub(p1_health, dmg2);

  attack_cooldown #(.CD_W(CD_W)) u_cd1 (
    .clk        (clk),
    .rst        (rst),
    .load       (g1),
    .load_value (cd1_val),
    .clear      (go),
    .enable     (1'b1),
    .ready      (p1_rdy)
  );

  attack_cooldown #(.CD_W(CD_W)) u_cd2 (
    .clk        (clk),
    .rst        (rst),
    .load       (g2),
    .load_value (cd2_val),
    .clear      (go),
    .enable     (1'b1),
    .ready      (p2_rdy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      round_start <= 1'b0;
      p1_health   <= 4'(HEALTH_MAX);
      p2_health   <= 4'(HEALTH_MAX);
      hit_pulse   <= 1'b0;
      hit_player  <= 1'b0;
      winner      <= WIN_NONE;
    end else begin
      hit_pulse <= 1'b0;
      unique case (st_q)
        ST_IDLE, ST_OVER: begin
          if (go) begin
            st_q      <= ST_COUNTDOWN;
            cnt_q     <= CD_W'(COUNTDOWN_CYC - 1);
            p1_health <= 4'(HEALTH_MAX);
            p2_health <= 4'(HEALTH_MAX);
            winner    <= WIN_NONE;
          end
        end
        ST_COUNTDOWN: begin
          if (cnt_q == '0) begin
            st_q        <= ST_FIGHT;
            round_start <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CD_W'(1);
          end
        end
        ST_FIGHT: begin
          if (p1_atk && p2_atk) ptr_q <= ~ptr_q;
          if (g1) begin
            p2_health  <= p2_rem;
            hit_pulse  <= 1'b1;
            hit_player <= 1'b1;
            if (p2_rem == 4'd0) begin
              st_q        <= ST_OVER;
              round_start <= 1'b0;
              winner      <= WIN_P1;
            end
          end
          if (g2) begin
            p1_health  <= p1_rem;
            hit_pulse  <= 1'b1;
            hit_player <= 1'b0;
            if (p1_rem == 4'd0) begin
              st_q        <= ST_OVER;
              round_start <= 1'b0;
              winner      <= WIN_P2;
            end
          end
        end
      endcase
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_fight_round_ctrl.sv
// Self-checking bench for fight_round_ctrl.
// Directed scenarios plus random traffic against a behavioural model.
module tb_fight_round_ctrl;

  localparam int HMAX = 15;
  localparam int LDMG = 1;
  localparam int HDMG = 3;
  localparam int LCD  = 4;
  localparam int HCD  = 12;
  localparam int CCYC = 16;

  logic       clk;
  logic       rst;
  logic [3:0] p1_cmd;
  logic       p1_cmd_valid;
  logic [3:0] p2_cmd;
  logic       p2_cmd_valid;
  logic       round_start;
  logic [1:0] state;
  logic [3:0] p1_health;
  logic [3:0] p2_health;
  logic       hit_pulse;
  logic       hit_player;
  logic [1:0] winner;

  int vectors;
  int miscompares;

  int m_st, m_cnt, m_h1, m_h2, m_cd1, m_cd2;
  int m_ptr, m_rs, m_hit, m_hp, m_win;

  logic [14:0] obs;
  assign obs = {state, round_start, p1_health, p2_health,
                hit_pulse, hit_player, winner};

  fight_round_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .p1_cmd       (p1_cmd),
    .p1_cmd_valid (p1_cmd_valid),
    .p2_cmd       (p2_cmd),
    .p2_cmd_valid (p2_cmd_valid),
    .round_start  (round_start),
    .state        (state),
    .p1_health    (p1_health),
    .p2_health    (p2_health),
    .hit_pulse    (hit_pulse),
    .hit_player   (hit_player),
    .winner       (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] exp_vec();
    return {2'(m_st), 1'(m_rs), 4'(m_h1), 4'(m_h2),
            1'(m_hit), 1'(m_hp), 2'(m_win)};
  endfunction

  function automatic int dmg_of(input logic [3:0] c);
    return (c == 4'h2) ? HDMG : LDMG;
  endfunction

  function automatic int cd_of(input logic [3:0] c);
    return (c == 4'h2) ? HCD : LCD;
  endfunction

  // Phases: 0 idle, 1 countdown, 2 fight, 3 over
  task automatic model_step(input bit r,
                            input logic [3:0] c1, input bit v1,
                            input logic [3:0] c2, input bit v2);
    bit e1, e2, g1, g2, st;
    if (r) begin
      m_st = 0; m_rs = 0; m_hit = 0; m_hp = 0; m_win = 0;
      m_h1 = HMAX; m_h2 = HMAX; m_cd1 = 0; m_cd2 = 0;
      m_cnt = 0; m_ptr = 0;
      return;
    end
    e1 = (m_st == 2) && v1 && (c1 == 4'h1 || c1 == 4'h2) && (m_cd1 == 0);
    e2 = (m_st == 2) && v2 && (c2 == 4'h1 || c2 == 4'h2) && (m_cd2 == 0);
    st = (v1 && c1 == 4'h3) || (v2 && c2 == 4'h3);
    m_hit = 0;
    if (m_cd1 > 0) m_cd1--;
    if (m_cd2 > 0) m_cd2--;
    case (m_st)
      0, 3: if (st) begin
        m_st = 1; m_cnt = CCYC - 1; m_h1 = HMAX; m_h2 = HMAX;
        m_win = 0; m_cd1 = 0; m_cd2 = 0;
      end
      1: if (m_cnt == 0) begin m_st = 2; m_rs = 1; end
         else m_cnt--;
      default: begin
        g1 = e1 && (!e2 || m_ptr == 0);
        g2 = e2 && !g1;
        if (e1 && e2) m_ptr = g1 ? 1 : 0;
        if (g1) begin
          m_h2 = (m_h2 > dmg_of(c1)) ? m_h2 - dmg_of(c1) : 0;
          m_cd1 = cd_of(c1); m_hit = 1; m_hp = 1;
          if (m_h2 == 0) begin m_st = 3; m_rs = 0; m_win = 1; end
        end
        if (g2) begin
          m_h1 = (m_h1 > dmg_of(c2)) ? m_h1 - dmg_of(c2) : 0;
          m_cd2 = cd_of(c2); m_hit = 1; m_hp = 0;
          if (m_h1 == 0) begin m_st = 3; m_rs = 0; m_win = 2; end
        end
      end
    endcase
  endtask

  task automatic cyc(input bit r,
                     input logic [3:0] c1, input bit v1,
                     input logic [3:0] c2, input bit v2);
    rst = r;
    p1_cmd = c1; p1_cmd_valid = v1;
    p2_cmd = c2; p2_cmd_valid = v2;
    @(posedge clk);
    model_step(r, c1, v1, c2, v2);
    @(negedge clk);
    rst = 1'b0; p1_cmd_valid = 1'b0; p2_cmd_valid = 1'b0;
  endtask

  task automatic idle_check(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      cyc(0, 4'h0, 0, 4'h0, 0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %h want %h", name, i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset();
    cyc(1, 4'h0, 0, 4'h0, 0);
    cyc(1, 4'h2, 1, 4'h3, 1);
    vectors++;
    if (obs !== {2'b00, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", obs,
               {2'b00, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0, 2'b00});
    end
    cyc(0, 4'h1, 1, 4'h2, 1);
    vectors++;
    if (state !== 2'b00 || hit_pulse !== 1'b0 || p2_health !== 4'd15) begin
      miscompares++;
      $display("FAIL idle_attack: state %b hit %b p2 %0d want 00 0 15",
               state, hit_pulse, p2_health);
    end
  endtask

  task automatic test_countdown();
    cyc(0, 4'h3, 1, 4'h0, 0);
    for (int i = 1; i <= CCYC; i++) begin
      vectors++;
      if (state !== 2'b01 || round_start !== 1'b0) begin
        miscompares++;
        $display("FAIL countdown[%0d]: state %b rs %b want 01 0",
                 i, state, round_start);
      end
      cyc(0, 4'h0, 0, 4'h0, 0);
    end
    vectors++;
    if (state !== 2'b10 || round_start !== 1'b1 ||
        p1_health !== 4'd15 || p2_health !== 4'd15) begin
      miscompares++;
      $display("FAIL fight_entry: state %b rs %b h %0d/%0d want 10 1 15/15",
               state, round_start, p1_health, p2_health);
    end
  endtask

  task automatic test_heavy_cooldown();
    cyc(0, 4'h2, 1, 4'h0, 0);
    vectors++;
    if (p2_health !== 4'd12 || hit_pulse !== 1'b1 || hit_player !== 1'b1) begin
      miscompares++;
      $display("FAIL heavy_hit: p2 %0d hit %b who %b want 12 1 1",
               p2_health, hit_pulse, hit_player);
    end
    idle_check(4, "heavy_wait1");
    cyc(0, 4'h2, 1, 4'h0, 0);
    vectors++;
    if (p2_health !== 4'd12 || hit_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL cd_drop: p2 %0d hit %b want 12 0", p2_health, hit_pulse);
    end
    idle_check(7, "heavy_wait2");
    cyc(0, 4'h2, 1, 4'h0, 0);
    vectors++;
    if (p2_health !== 4'd9 || hit_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL cd_expire: p2 %0d hit %b want 9 1", p2_health, hit_pulse);
    end
    idle_check(13, "heavy_wait3");
  endtask

  task automatic test_contention();
    cyc(0, 4'h1, 1, 4'h1, 1);
    vectors++;
    if (p1_health !== 4'd15 || p2_health !== 4'd8 || hit_player !== 1'b1) begin
      miscompares++;
      $display("FAIL tie_p1: h %0d/%0d who %b want 15/8 1",
               p1_health, p2_health, hit_player);
    end
    idle_check(5, "tie_wait1");
    cyc(0, 4'h1, 1, 4'h1, 1);
    vectors++;
    if (p1_health !== 4'd14 || p2_health !== 4'd8 || hit_player !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_p2: h %0d/%0d who %b want 14/8 0",
               p1_health, p2_health, hit_player);
    end
    idle_check(5, "tie_wait2");
  endtask

  task automatic test_ko();
    cyc(0, 4'h2, 1, 4'h0, 0);
    idle_check(13, "ko_wait1");
    cyc(0, 4'h2, 1, 4'h0, 0);
    vectors++;
    if (p2_health !== 4'd2) begin
      miscompares++;
      $display("FAIL ko_pre: p2 %0d want 2", p2_health);
    end
    idle_check(13, "ko_wait2");
    cyc(0, 4'h2, 1, 4'h0, 0);
    vectors++;
    if (p2_health !== 4'd0 || state !== 2'b11 ||
        winner !== 2'b01 || round_start !== 1'b0) begin
      miscompares++;
      $display("FAIL ko: p2 %0d st %b win %b rs %b want 0 11 01 0",
               p2_health, state, winner, round_start);
    end
    idle_check(13, "over_wait");
    cyc(0, 4'h2, 1, 4'h2, 1);
    cyc(0, 4'h1, 1, 4'h1, 1);
    vectors++;
    if (p1_health !== 4'd14 || p2_health !== 4'd0 ||
        hit_pulse !== 1'b0 || winner !== 2'b01) begin
      miscompares++;
      $display("FAIL over_hold: h %0d/%0d hit %b win %b want 14/0 0 01",
               p1_health, p2_health, hit_pulse, winner);
    end
  endtask

  task automatic test_restart_ignored();
    cyc(0, 4'h0, 0, 4'h3, 1);
    vectors++;
    if (state !== 2'b01 || p1_health !== 4'd15 ||
        p2_health !== 4'd15 || winner !== 2'b00) begin
      miscompares++;
      $display("FAIL restart: st %b h %0d/%0d win %b want 01 15/15 00",
               state, p1_health, p2_health, winner);
    end
    for (int i = 0; i < CCYC; i++) begin
      cyc(0, 4'($urandom_range(0, 15)), 1, 4'($urandom_range(0, 15)), 1);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL cd_ignore[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
    cyc(0, 4'h7, 1, 4'h3, 1);
    cyc(0, 4'h3, 1, 4'h7, 1);
    vectors++;
    if (state !== 2'b10 || hit_pulse !== 1'b0 ||
        p1_health !== 4'd15 || p2_health !== 4'd15) begin
      miscompares++;
      $display("FAIL bad_codes: st %b hit %b h %0d/%0d want 10 0 15/15",
               state, hit_pulse, p1_health, p2_health);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 4'h1, 1, 4'h2, 1);
    vectors++;
    if (state !== 2'b00 || hit_pulse !== 1'b0 || round_start !== 1'b0 ||
        p1_health !== 4'd15 || p2_health !== 4'd15) begin
      miscompares++;
      $display("FAIL reset_mid: st %b hit %b rs %b h %0d/%0d want 00 0 0 15/15",
               state, hit_pulse, round_start, p1_health, p2_health);
    end
  endtask

  task automatic test_random();
    logic [3:0] codes [5];
    logic [3:0] c1, c2;
    bit r;
    codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7};
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      c1 = codes[$urandom_range(0, 4)];
      c2 = codes[$urandom_range(0, 4)];
      cyc(r, c1, 1'($urandom_range(0, 1)), c2, 1'($urandom_range(0, 1)));
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    p1_cmd = 4'h0; p1_cmd_valid = 1'b0;
    p2_cmd = 4'h0; p2_cmd_valid = 1'b0;
    model_step(1, 4'h0, 0, 4'h0, 0);
    @(negedge clk);
    test_reset();
    test_countdown();
    test_heavy_cooldown();
    test_contention();
    test_ko();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
